// File: rtl/riscv_phase_sequencer.sv
// riscv_phase_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM with memory timeout fault.
// Optional performance counters are enabled by defining RISCV_PERF_CNT_EN.
module riscv_phase_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic             memReady,
   output logic             memReq,
   output logic             MemRW,
   output logic             irWrite,
   output logic             pcWrite,
   output logic             regWriteEnable,
   output logic [2:0]       phase,
   output logic             busy,
   output logic             fault,
   output logic [CNT_W-1:0] cycleCount,
   output logic [CNT_W-1:0] instRetired
);
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXECUTE   = 3'd3,
      MEM       = 3'd4,
      WRITEBACK = 3'd5,
      FAULT     = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [6:0]      op_q, op_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            waiting, expired, legal;

   assign waiting = (state_q == FETCH || state_q == MEM) && !memReady;
   assign expired = waiting && tmo_q == TW'(MEM_TIMEOUT);
   assign legal   = opcode == OP_IMM || opcode == OP_REG || opcode == OP_LD || opcode == OP_ST;

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      memReq         = 1'b0;
      MemRW          = 1'b0;
      irWrite        = 1'b0;
      pcWrite        = 1'b0;
      regWriteEnable = 1'b0;
      case (state_q)
         IDLE:      state_d = run ? FETCH : IDLE;
         FETCH: begin
            memReq  = 1'b1;
            irWrite = memReady;
            state_d = memReady ? DECODE : expired ? FAULT : FETCH;
         end
         DECODE: begin
            op_d    = opcode;
            state_d = legal ? EXECUTE : FAULT;
         end
         EXECUTE:   state_d = (op_q == OP_LD || op_q == OP_ST) ? MEM : WRITEBACK;
         MEM: begin
            memReq  = 1'b1;
            MemRW   = op_q == OP_ST;
            pcWrite = memReady && op_q == OP_ST;
            state_d = !memReady ? (expired ? FAULT : MEM)
                    : op_q == OP_ST ? (run ? FETCH : IDLE) : WRITEBACK;
         end
         WRITEBACK: begin
            regWriteEnable = 1'b1;
            pcWrite        = 1'b1;
            state_d        = run ? FETCH : IDLE;
         end
         default:   state_d = FAULT;
      endcase
      // any phase change restarts the wait count, so entry to FETCH/MEM always starts at zero
      tmo_d = state_d != state_q ? '0 : waiting ? tmo_q + TW'(1) : tmo_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         tmo_q   <= tmo_d;
      end
   end

   assign phase = state_q;
   assign busy  = state_q != IDLE && state_q != FAULT;
   assign fault = state_q == FAULT;

`ifdef RISCV_PERF_CNT_EN
   logic [CNT_W-1:0] cyc_q, ret_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         if (busy) cyc_q <= cyc_q + CNT_W'(1);
         if (pcWrite) ret_q <= ret_q + CNT_W'(1);
      end
   end
   assign cycleCount  = cyc_q;
   assign instRetired = ret_q;
`else
   assign cycleCount  = '0;
   assign instRetired = '0;
`endif
endmodule
